tdp18k_port_arbiter: RTL



---
 rtl/tdp18k_arb_pkg.sv | 20 ++
 rtl/tdp18k_port_arbiter_if.sv | 37 +++
 rtl/tdp18k_arb_pick.sv | 24 ++
 rtl/tdp18k_port_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/tdp18k_arb_pkg.sv
// Shared types and constants for the TDP18K port arbiter.
// The integrator ties RAM RMODE/WMODE to MODE_18 when using this arbiter.
package tdp18k_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned BE_PER_REQ = 2;
    localparam logic [2:0] MODE_18 = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // One-hot vector selecting requester idx.
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        req_onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/tdp18k_port_arbiter_if.sv
// Requester and RAM-port bus of the TDP18K port arbiter.
// master: fabric requesters plus the RAM read-data return; slave: the arbiter.
interface tdp18k_port_arbiter_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 18
);
    import tdp18k_arb_pkg::*;

    logic [NUM_REQ-1:0]            REQ_i;
    logic [NUM_REQ-1:0]            WE_i;
    logic [NUM_REQ-1:0]            LOCK_i;
    logic [NUM_REQ*ADDR_W-1:0]     ADDR_i;
    logic [NUM_REQ*DATA_W-1:0]     WDATA_i;
    logic [NUM_REQ*BE_PER_REQ-1:0] BE_i;
    logic [NUM_REQ-1:0]            GNT_o;
    logic [NUM_REQ-1:0]            RVALID_o;
    logic [DATA_W-1:0]             RDATA_o;
    logic                          RAM_WEN_o;
    logic                          RAM_REN_o;
    logic [ADDR_W-1:0]             RAM_ADDR_o;
    logic [DATA_W-1:0]             RAM_WDATA_o;
    logic [BE_PER_REQ-1:0]         RAM_BE_o;
    logic [DATA_W-1:0]             RAM_RDATA_i;

    modport master (
        output REQ_i, WE_i, LOCK_i, ADDR_i, WDATA_i, BE_i, RAM_RDATA_i,
        input  GNT_o, RVALID_o, RDATA_o,
               RAM_WEN_o, RAM_REN_o, RAM_ADDR_o, RAM_WDATA_o, RAM_BE_o
    );

    modport slave (
        input  REQ_i, WE_i, LOCK_i, ADDR_i, WDATA_i, BE_i, RAM_RDATA_i,
        output GNT_o, RVALID_o, RDATA_o,
               RAM_WEN_o, RAM_REN_o, RAM_ADDR_o, RAM_WDATA_o, RAM_BE_o
    );

endinterface

// File: rtl/tdp18k_arb_pick.sv
// Combinational round-robin picker: lock owner first, else the requester
// that did not win last, else whichever single requester is asking.
module tdp18k_arb_pick
    import tdp18k_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_gnt,
    input  logic               lock_vld,
    input  logic               lock_own,
    output logic [NUM_REQ-1:0] gnt_c
);

    always_comb begin
        gnt_c = '0;
        if (lock_vld && req[lock_own]) begin
            gnt_c = req_onehot(lock_own);
        end else if (&req) begin
            gnt_c = req_onehot(~last_gnt);
        end else begin
            gnt_c = req;
        end
    end

endmodule

// File: rtl/tdp18k_port_arbiter.sv
// Two-requester arbiter sharing one TDP18K RAM port with bounded burst locking.
// Optional macro TDP18K_ARB_RDATA_REG_EN adds a read-return register stage.
module tdp18k_port_arbiter
    import tdp18k_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   CLK_i,
    input  logic                   RST_ni,
    tdp18k_port_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_q, state_d;
    logic               last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_c;
    logic               rd_pend_q, rd_tag_q;

    logic [NUM_REQ-1:0] req_c, gnt_c;
    logic               xfer_c, sel_c, rd_c;
    logic               lock_vld_c, lock_own_c;
    logic [ADDR_W-1:0]  addr_c;
    logic [DATA_W-1:0]  wdata_c;
    logic [BE_PER_REQ-1:0] be_c;

    // Requests are masked while reset is asserted so every output reads 0.
    assign req_c      = bus.REQ_i & {NUM_REQ{RST_ni}};
    assign lock_vld_c = (state_q != IDLE);
    assign lock_own_c = (state_q == LOCK1);

    tdp18k_arb_pick u_pick (
        .req      (req_c),
        .last_gnt (last_gnt_q),
        .lock_vld (lock_vld_c),
        .lock_own (lock_own_c),
        .gnt_c    (gnt_c)
    );

    assign xfer_c    = |gnt_c;
    assign sel_c     = gnt_c[1];
    assign rd_c      = xfer_c & ~bus.WE_i[sel_c];
    assign bus.GNT_o = gnt_c;

    assign addr_c  = sel_c ? bus.ADDR_i[2*ADDR_W-1:ADDR_W]  : bus.ADDR_i[ADDR_W-1:0];
    assign wdata_c = sel_c ? bus.WDATA_i[2*DATA_W-1:DATA_W] : bus.WDATA_i[DATA_W-1:0];
    assign be_c    = sel_c ? bus.BE_i[2*BE_PER_REQ-1:BE_PER_REQ] : bus.BE_i[BE_PER_REQ-1:0];

    // RAM pins follow the granted requester and stay at 0 when idle.
    always_comb begin
        bus.RAM_WEN_o   = 1'b0;
        bus.RAM_REN_o   = 1'b0;
        bus.RAM_ADDR_o  = '0;
        bus.RAM_WDATA_o = '0;
        bus.RAM_BE_o    = '0;
        if (xfer_c) begin
            bus.RAM_WEN_o   = bus.WE_i[sel_c];
            bus.RAM_REN_o   = ~bus.WE_i[sel_c];
            bus.RAM_ADDR_o  = addr_c;
            bus.RAM_WDATA_o = wdata_c;
            bus.RAM_BE_o    = be_c;
        end
    end

    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            rd_tag_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_c;
            if (xfer_c) begin
                rd_tag_q <= sel_c;
            end
        end
    end

    // Lock FSM: an owner transfer extends the burst until LOCK drops or the cap
    // is hit; any other outcome while locked falls back to IDLE or a new lock.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        cnt_inc_c  = cnt_q + CNT_W'(1);
        if (xfer_c) begin
            last_gnt_d = sel_c;
            if (lock_vld_c && (sel_c == lock_own_c)) begin
                if (!bus.LOCK_i[sel_c] || (cnt_inc_c == CNT_W'(MAX_BURST))) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end else if (bus.LOCK_i[sel_c] && (MAX_BURST > 1)) begin
                state_d = sel_c ? LOCK1 : LOCK0;
                cnt_d   = CNT_W'(1);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (lock_vld_c) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

`ifdef TDP18K_ARB_RDATA_REG_EN
    logic [NUM_REQ-1:0] rvalid_q;
    logic [DATA_W-1:0]  rdata_q;

    // Extra return stage; read data holds between valid beats.
    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_pend_q ? req_onehot(rd_tag_q) : '0;
            if (rd_pend_q) begin
                rdata_q <= bus.RAM_RDATA_i;
            end
        end
    end

    assign bus.RVALID_o = rvalid_q;
    assign bus.RDATA_o  = rdata_q;
`else
    assign bus.RVALID_o = rd_pend_q ? req_onehot(rd_tag_q) : '0;
    assign bus.RDATA_o  = rd_pend_q ? bus.RAM_RDATA_i : '0;
`endif

endmodule
